// File: rtl/dffram_bwe_pkg.sv
// Shared definitions for the dffram_bwe RAM slice.
//   BYTE_W  : bits per byte lane
//   clog2   : address-width helper, usable in parameter defaults
//   state_t : clear-sequencer states
package dffram_pkg;

    localparam int BYTE_W = 8;

    // Width needed to address n distinct words (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (((n - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/dffram_bwe_if.sv
// Access bus of the dffram_bwe RAM.
//   en   : port enable
//   we   : per-byte write enables (we[i] covers D[8i+7:8i])
//   addr : word address
//   D    : write data
//   Q    : registered read data
//   busy : clear sweep in progress, accesses ignored
// master drives the request side, slave is the RAM.
interface dffram_bwe_if
    import dffram_pkg::*;
#(
    parameter int WORDS = 8,
    parameter int WSIZE = 1,
    parameter int AW    = clog2(WORDS)
) ();

    localparam int DW = BYTE_W * WSIZE;

    logic             en;
    logic [WSIZE-1:0] we;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    D;
    logic [DW-1:0]    Q;
    logic             busy;

    modport master (
        output en, we, addr, D,
        input  Q, busy
    );

    modport slave (
        input  en, we, addr, D,
        output Q, busy
    );

endinterface

// File: rtl/dffram_bwe_word.sv
// One RAM word built from byte-enabled flip-flops.
//   clk : clock
//   sel : word selected for a write this cycle
//   we  : per-byte write enables
//   D   : write data
//   clr : zero the whole word (clear sweep), overrides sel
//   Q   : stored word
module dffram_word
    import dffram_pkg::*;
#(
    parameter int WSIZE = 1
) (
    input  logic                    clk,
    input  logic                    sel,
    input  logic [WSIZE-1:0]        we,
    input  logic [BYTE_W*WSIZE-1:0] D,
    input  logic                    clr,
    output logic [BYTE_W*WSIZE-1:0] Q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            Q <= '0;
        end else if (sel) begin
            for (int i = 0; i < WSIZE; i++) begin
                if (we[i]) begin
                    Q[BYTE_W*i +: BYTE_W] <= D[BYTE_W*i +: BYTE_W];
                end
            end
        end
    end

endmodule

// File: rtl/dffram_bwe.sv
// Parametrised single-port DFF RAM with per-byte write enables, a
// registered read port and a post-reset clear sweep.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, restarts the clear sweep
//   bus : slave side of dffram_bwe_if (en, we, addr, D, Q, busy)
module dffram_bwe
    import dffram_pkg::*;
#(
    parameter int WORDS = 8,
    parameter int WSIZE = 1,
    parameter int AW    = clog2(WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    dffram_bwe_if.slave bus
);

    localparam int DW = BYTE_W * WSIZE;

    state_t         state;
    logic [AW-1:0]  cnt;
    logic           busy_r;
    logic [DW-1:0]  q_p1;

    logic [DW-1:0]    words [WORDS];
    logic [WORDS-1:0] wr_sel;
    logic [WORDS-1:0] clr_sel;
    logic [DW-1:0]    rd_data;
    logic             do_write;
    logic             clearing;

    // The reset edge itself neither clears nor writes; the sweep starts
    // on the following edge from cnt = 0.
    assign clearing = !rst && (state == CLEAR);
    assign do_write = !rst && (state == IDLE) && bus.en && (|bus.we);

    // Address decode and read mux. Addresses at or beyond WORDS match no
    // word, so writes there are dropped and reads return zero.
    always_comb begin
        wr_sel  = '0;
        clr_sel = '0;
        rd_data = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (bus.addr == AW'(w)) begin
                wr_sel[w] = do_write;
                rd_data   = words[w];
            end
            clr_sel[w] = clearing && (cnt == AW'(w));
        end
    end

    for (genvar w = 0; w < WORDS; w++) begin : g_word
        dffram_word #(
            .WSIZE (WSIZE)
        ) u_word (
            .clk (clk),
            .sel (wr_sel[w]),
            .we  (bus.we),
            .D   (bus.D),
            .clr (clr_sel[w]),
            .Q   (words[w])
        );
    end

    // Clear sequencer and read register. Q only updates on an IDLE read,
    // so it holds across writes, disabled cycles and the whole sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_r <= 1'b1;
            q_p1   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == AW'(WORDS - 1)) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.en && (bus.we == '0)) begin
                        q_p1 <= rd_data;
                    end
                end
                default: begin
                    state  <= CLEAR;
                    cnt    <= '0;
                    busy_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Q    = q_p1;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_dffram_bwe.sv
// Directed bench for dffram_bwe: an 8x32 instance and a 6x8 instance
// (non-power-of-two depth) run side by side against a behavioural model.
module tb_dffram_bwe;

    logic clk;
    logic rst8;
    logic rst6;

    dffram_bwe_if #(.WORDS(8), .WSIZE(4)) if8 ();
    dffram_bwe_if #(.WORDS(6), .WSIZE(1)) if6 ();

    dffram_bwe #(.WORDS(8), .WSIZE(4)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (if8.slave)
    );

    dffram_bwe #(.WORDS(6), .WSIZE(1)) dut6 (
        .clk (clk),
        .rst (rst6),
        .bus (if6.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Behavioural model: memory image, expected Q, and the number of
    // clear cycles still to run (busy while that is non-zero).
    logic [31:0] m8 [8];
    logic [31:0] eq8;
    int          left8 = 0;
    logic [7:0]  m6 [6];
    logic [7:0]  eq6;
    int          left6 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic op8(input logic en, input logic [3:0] we, input logic [2:0] addr, input logic [31:0] d);
        if8.en = en; if8.we = we; if8.addr = addr; if8.D = d;
    endtask

    task automatic op6(input logic en, input logic we, input logic [2:0] addr, input logic [7:0] d);
        if6.en = en; if6.we = we; if6.addr = addr; if6.D = d;
    endtask

    // One clock edge; the model applies the operation that was presented
    // to each RAM at that edge.
    task automatic tick();
        logic       r8, e8, r6, e6, w6;
        logic [3:0] w8;
        logic [2:0] a8, a6;
        logic [31:0] d8;
        logic [7:0]  d6;
        r8 = rst8; e8 = if8.en; w8 = if8.we; a8 = if8.addr; d8 = if8.D;
        r6 = rst6; e6 = if6.en; w6 = if6.we[0]; a6 = if6.addr; d6 = if6.D;
        @(posedge clk);
        if (r8) begin
            eq8 = '0; left8 = 8;
        end else if (left8 > 0) begin
            m8[8 - left8] = '0; left8--;
        end else if (e8) begin
            if (w8 == 4'b0000) eq8 = (a8 < 8) ? m8[a8] : 32'h0;
            else for (int b = 0; b < 4; b++) if (w8[b]) m8[a8][8*b +: 8] = d8[8*b +: 8];
        end
        if (r6) begin
            eq6 = '0; left6 = 6;
        end else if (left6 > 0) begin
            m6[6 - left6] = '0; left6--;
        end else if (e6) begin
            if (!w6) eq6 = (a6 < 6) ? m6[a6] : 8'h00;
            else if (a6 < 6) m6[a6] = d6;
        end
        #1;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("q8",    if8.Q,          eq8);
            chk("busy8", {31'd0, if8.busy}, {31'd0, left8 > 0});
            chk("q6",    {24'd0, if6.Q}, {24'd0, eq6});
            chk("busy6", {31'd0, if6.busy}, {31'd0, left6 > 0});
        end
    end

    initial begin
        int n;
        rst8 = 1'b1; rst6 = 1'b1;
        op8(1'b0, 4'h0, 3'd0, 32'h0);
        op6(1'b0, 1'b0, 3'd0, 8'h00);

        // Reset, then try to write during the sweep; it must be ignored.
        tick();
        chk_on = 1'b1;
        rst8 = 1'b0; rst6 = 1'b0;
        chk("q8_after_rst", if8.Q, 32'h0);
        op8(1'b1, 4'hF, 3'd2, 32'hFFFF_FFFF);
        n = 0;
        while (if8.busy && n < 20) begin
            n++;
            tick();
        end
        chk("busy8_cycles", n, 8);
        op8(1'b0, 4'h0, 3'd0, 32'h0);

        // Every word reads back zero one cycle after the request.
        for (int a = 0; a < 8; a++) begin
            op8(1'b1, 4'h0, 3'(a), 32'h0);
            tick();
            chk("clear_read", if8.Q, 32'h0);
        end

        // Full-word write, read-after-write, Q held during a write.
        op8(1'b1, 4'hF, 3'd3, 32'hDEAD_BEEF); tick();
        op8(1'b1, 4'h0, 3'd3, 32'h0);         tick();
        chk("read3", if8.Q, 32'hDEAD_BEEF);
        op8(1'b1, 4'hF, 3'd5, 32'h1122_3344); tick();
        chk("q_hold_write", if8.Q, 32'hDEAD_BEEF);
        op8(1'b1, 4'b0101, 3'd5, 32'hAABB_CCDD); tick();
        op8(1'b1, 4'h0, 3'd5, 32'h0);            tick();
        chk("byte_en", if8.Q, 32'h11BB_33DD);

        // Port disabled: write enables present but nothing changes.
        op8(1'b0, 4'hF, 3'd5, 32'h0); tick();
        chk("en0_hold", if8.Q, 32'h11BB_33DD);
        op8(1'b1, 4'h0, 3'd5, 32'h0); tick();
        chk("en0_nowrite", if8.Q, 32'h11BB_33DD);

        // Reset restart part way through a fresh sweep.
        op8(1'b1, 4'hF, 3'd7, 32'h1234_5678); tick();
        op8(1'b1, 4'h0, 3'd7, 32'h0);         tick();
        chk("read7", if8.Q, 32'h1234_5678);
        op8(1'b0, 4'h0, 3'd0, 32'h0);
        rst8 = 1'b1; tick(); rst8 = 1'b0;
        tick(); tick();
        chk("busy_mid", {31'd0, if8.busy}, 32'd1);
        rst8 = 1'b1; tick(); rst8 = 1'b0;
        n = 0;
        while (if8.busy && n < 20) begin
            n++;
            tick();
        end
        chk("busy8_restart", n, 8);
        op8(1'b1, 4'h0, 3'd7, 32'h0); tick();
        chk("read7_cleared", if8.Q, 32'h0);
        op8(1'b0, 4'h0, 3'd0, 32'h0);

        // Depth 6: addresses 6 and 7 are outside the array.
        op6(1'b1, 1'b1, 3'd5, 8'hA5); tick();
        op6(1'b1, 1'b1, 3'd6, 8'h5A); tick();
        op6(1'b1, 1'b1, 3'd7, 8'h5A); tick();
        op6(1'b1, 1'b0, 3'd5, 8'h00); tick();
        chk("d6_read5", {24'd0, if6.Q}, 32'hA5);
        op6(1'b1, 1'b0, 3'd6, 8'h00); tick();
        chk("d6_read6", {24'd0, if6.Q}, 32'h00);
        op6(1'b1, 1'b0, 3'd5, 8'h00); tick();
        op6(1'b1, 1'b0, 3'd7, 8'h00); tick();
        chk("d6_read7", {24'd0, if6.Q}, 32'h00);
        op6(1'b1, 1'b0, 3'd2, 8'h00); tick();
        chk("d6_read2", {24'd0, if6.Q}, 32'h00);
        op6(1'b0, 1'b0, 3'd0, 8'h00);
        tick(); tick();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
